// File: rtl/slice_scheduler.sv
// slice_scheduler: captures one word per input handshake, then walks a base
// index across it and emits each SLICE_W-bit window, ascending (+:) or
// descending (-:) depending on the direction captured with the word.
module slice_scheduler #(
    parameter int DATA_W  = 8,
    parameter int SLICE_W = 4,
    parameter int STRIDE  = 2,
    localparam int NUM_SLICES = (DATA_W - SLICE_W) / STRIDE + 1,
    localparam int BASE_W     = (DATA_W > 1) ? $clog2(DATA_W) : 1,
    localparam int IDX_W      = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_data,
    input  logic               in_minus,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SLICE_W-1:0] out_slice,
    output logic [BASE_W-1:0]  out_base,
    output logic               out_last,
    output logic               busy,
    output logic [7:0]         words_done
);

    typedef enum logic {IDLE, EMIT} state_t;

    state_t              state, state_nx;
    logic [DATA_W-1:0]   word_q;
    logic                minus_q;
    logic [BASE_W-1:0]   base;
    logic [IDX_W-1:0]    idx;
    logic [BASE_W-1:0]   lo;
    logic                last, take_in, take_out;

    assign last     = (idx == IDX_W'(NUM_SLICES - 1));
    // flush wins over both handshakes: nothing is accepted in a flush cycle
    assign take_in  = (state == IDLE) && in_valid && !flush;
    assign take_out = (state == EMIT) && out_ready && !flush;

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // next-state: leave EMIT on flush or on the final slice handshake
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (take_in) state_nx = EMIT;
            EMIT: if (flush || (take_out && last)) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // outputs: registered state plus the window of word_q at base; a -:
    // window at base is the +: window starting SLICE_W-1 bits lower
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == EMIT);
        busy      = (state == EMIT);
        out_last  = (state == EMIT) && last;
        out_base  = '0;
        out_slice = '0;
        lo        = minus_q ? base - BASE_W'(SLICE_W - 1) : base;
        if (state == EMIT) begin
            out_base  = base;
            out_slice = SLICE_W'(word_q >> lo);
        end
    end

    // datapath: capture word, step base/idx per accepted slice, count words
    always_ff @(posedge clk) begin
        if (rst) begin
            word_q     <= '0;
            minus_q    <= 1'b0;
            base       <= '0;
            idx        <= '0;
            words_done <= '0;
        end else if (take_in) begin
            word_q  <= in_data;
            minus_q <= in_minus;
            base    <= in_minus ? BASE_W'(DATA_W - 1) : '0;
            idx     <= '0;
        end else if (take_out) begin
            if (last) begin
                words_done <= words_done + 8'd1;
            end else begin
                base <= minus_q ? base - BASE_W'(STRIDE) : base + BASE_W'(STRIDE);
                idx  <= idx + IDX_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_slice_scheduler.sv
// Bench for slice_scheduler: directed table of words with constant expected
// windows, hand-written flush/wrap/reset sequences, and a randomized run
// compared every cycle against a slice-index model of the block.
module tb_slice_scheduler;
    localparam int DW = 8, SW = 4, ST = 2;
    localparam int NS = (DW - SW) / ST + 1;

    logic         clk = 1'b0;
    logic         rst, in_valid, in_minus, flush, out_ready;
    logic [DW-1:0] in_data;
    logic         in_ready, out_valid, out_last, busy;
    logic [SW-1:0] out_slice;
    logic [2:0]   out_base;
    logic [7:0]   words_done;

    slice_scheduler #(.DATA_W(DW), .SLICE_W(SW), .STRIDE(ST)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_minus(in_minus), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_slice(out_slice),
        .out_base(out_base), .out_last(out_last), .busy(busy),
        .words_done(words_done)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;

    // model: busy flag, slice number within the word, captured word
    bit          m_busy = 1'b0;
    int          m_k = 0;
    logic [7:0]  m_word = '0;
    bit          m_minus = 1'b0;
    int          m_done = 0;

    function automatic int mbase(bit mi, int k);
        return mi ? (DW - 1 - k * ST) : (k * ST);
    endfunction

    function automatic int mslice(logic [7:0] w, bit mi, int k);
        int lo;
        logic [7:0] t;
        lo = mi ? mbase(mi, k) - (SW - 1) : mbase(mi, k);
        t  = w >> lo;
        return int'(t[SW-1:0]);
    endfunction

    task automatic chk(string name, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("m_in_ready", in_ready, !m_busy);
        chk("m_out_valid", out_valid, m_busy);
        chk("m_busy", busy, m_busy);
        chk("m_last", out_last, m_busy && (m_k == NS - 1));
        chk("m_base", out_base, m_busy ? mbase(m_minus, m_k) : 0);
        chk("m_slice", out_slice, m_busy ? mslice(m_word, m_minus, m_k) : 0);
        chk("m_done", words_done, m_done);
    endtask

    // apply one cycle of inputs, advance the model, then sample after the edge
    task automatic step(bit r, bit iv, logic [7:0] d, bit mi, bit fl, bit ordy);
        rst = r; in_valid = iv; in_data = d; in_minus = mi; flush = fl; out_ready = ordy;
        if (r) begin
            m_busy = 0; m_k = 0; m_done = 0;
        end else if (m_busy) begin
            if (fl) m_busy = 0;
            else if (ordy) begin
                if (m_k == NS - 1) begin m_busy = 0; m_done = (m_done + 1) % 256; end
                else m_k++;
            end
        end else if (iv && !fl) begin
            m_busy = 1; m_k = 0; m_word = d; m_minus = mi;
        end
        @(posedge clk); #1;
        check_model();
    endtask

    typedef struct {
        logic [7:0] data;
        bit         minus;
        bit         bp;
        logic [3:0] sl [NS];
        int         bs [NS];
    } vec_t;

    vec_t tbl [4];
    int   saved;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{8'b11010101, 1'b0, 1'b0, '{4'b0101, 4'b0101, 4'b1101}, '{0, 2, 4}};
        tbl[1] = '{8'b11110000, 1'b1, 1'b0, '{4'b1111, 4'b1100, 4'b0000}, '{7, 5, 3}};
        tbl[2] = '{8'b10101010, 1'b0, 1'b1, '{4'b1010, 4'b1010, 4'b1010}, '{0, 2, 4}};
        tbl[3] = '{8'b00111100, 1'b1, 1'b1, '{4'b0011, 4'b1111, 4'b1100}, '{7, 5, 3}};

        rst = 1; in_valid = 0; in_data = '0; in_minus = 0; flush = 0; out_ready = 0;

        // reset: two cycles high, then idle
        step(1, 0, 8'h00, 0, 0, 0);
        step(1, 0, 8'h00, 0, 0, 0);
        step(0, 0, 8'h00, 0, 0, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_words_done", words_done, 0);
        chk("rst_busy", busy, 0);

        // directed words; rows with bp hold each slice one cycle before accepting
        for (int i = 0; i < 4; i++) begin
            step(0, 1, tbl[i].data, tbl[i].minus, 0, 0);
            for (int k = 0; k < NS; k++) begin
                if (tbl[i].bp) begin
                    chk("bp_slice", out_slice, tbl[i].sl[k]);
                    chk("bp_base", out_base, tbl[i].bs[k]);
                    step(0, 0, ~tbl[i].data, !tbl[i].minus, 0, 0);
                end
                chk("tbl_slice", out_slice, tbl[i].sl[k]);
                chk("tbl_base", out_base, tbl[i].bs[k]);
                chk("tbl_last", out_last, (k == NS - 1) ? 1 : 0);
                step(0, 0, ~tbl[i].data, 0, 0, 1);
            end
            chk("tbl_in_ready", in_ready, 1);
            chk("tbl_done", words_done, i + 1);
        end

        // flush after first slice, with out_ready high in the flush cycle
        saved = m_done;
        step(0, 1, 8'hA5, 0, 0, 0);
        step(0, 0, 8'h00, 0, 0, 1);
        step(0, 0, 8'h00, 0, 1, 1);
        chk("flush_valid", out_valid, 0);
        chk("flush_done", words_done, saved);
        step(0, 1, 8'h5A, 0, 1, 0);
        chk("flush_idle_ready", in_ready, 1);
        chk("flush_idle_valid", out_valid, 0);
        step(0, 1, 8'h5A, 0, 0, 0);
        chk("flush_next_base", out_base, 0);
        chk("flush_next_slice", out_slice, 4'hA);
        for (int k = 0; k < NS; k++) step(0, 0, 8'h00, 0, 0, 1);

        // counter wrap: 256 words after reset
        step(1, 0, 8'h00, 0, 0, 0);
        for (int w = 0; w < 256; w++) begin
            step(0, 1, 8'($urandom), 1'($urandom_range(0, 1)), 0, 0);
            for (int k = 0; k < NS; k++) step(0, 0, 8'h00, 0, 0, 1);
            if (w == 254) chk("wrap_255", words_done, 255);
        end
        chk("wrap_0", words_done, 0);

        // reset in the middle of a word
        step(0, 1, 8'hC3, 1, 0, 0);
        step(0, 0, 8'h00, 0, 0, 1);
        step(0, 0, 8'h00, 0, 0, 1);
        step(1, 0, 8'h00, 0, 0, 1);
        chk("midrst_valid", out_valid, 0);
        chk("midrst_ready", in_ready, 1);
        chk("midrst_done", words_done, 0);
        step(0, 0, 8'h00, 0, 0, 0);

        // randomized traffic against the model
        for (int c = 0; c < 500; c++) begin
            step(1'($urandom_range(0, 63) == 0), 1'($urandom_range(0, 1)), 8'($urandom),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0),
                 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
